holy_lsu: RTL and testbench

- Multi-cycle load/store unit between the core's datapath and a handshaked data-memory port.
- Accepts one load or store per request and converts byte/half/word accesses into a word-aligned memory transaction with byte enables.
- Stalls the core until the access completes.
- For loads, returns sign- or zero-extended data to the register-file write path as a write_back_t (data, valid).

---
 rtl/holy_lsu.sv | 171 +++++++++++++++++
 tb/tb_holy_lsu.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/holy_lsu.sv
// rtl/holy_lsu.sv - multi-cycle load/store unit with byte-enable memory port (option: LSU_MISALIGN_TRAP_EN)
module holy_lsu #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic        req_is_store_i,
    input  logic [2:0]  req_f3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        stall_o,
    output logic [32:0] wb_o,
    output logic        err_o,
    output logic        misalign_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [2:0] {
        F3_BYTE       = 3'b000,
        F3_HALFWORD   = 3'b001,
        F3_WORD       = 3'b010,
        F3_BYTE_U     = 3'b100,
        F3_HALFWORD_U = 3'b101
    } load_store_funct3_t;

    typedef struct packed {
        logic [31:0] data;
        logic        valid;
    } write_back_t;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         f3_q;
    logic [1:0]         lane_q;
    logic [31:0]        rdata_q;
    logic               err_q;
    logic               mis_q;
    logic [3:0]         be_d;
    logic [31:0]        wdata_d;
    logic               trap_d;
    logic [7:0]         byte_v;
    logic [15:0]        half_v;
    logic [31:0]        load_data;
    write_back_t        wb;

    // Request decode: lane steering of enables and replicated store data
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = req_wdata_i;
        trap_d  = 1'b0;
        case (req_f3_i)
            F3_BYTE, F3_BYTE_U: begin
                be_d    = 4'b0001 << req_addr_i[1:0];
                wdata_d = {4{req_wdata_i[7:0]}};
            end
            F3_HALFWORD, F3_HALFWORD_U: begin
                be_d    = 4'b0011 << {req_addr_i[1], 1'b0};
                wdata_d = {2{req_wdata_i[15:0]}};
            end
            default: ;
        endcase
        if (!req_is_store_i) be_d = 4'b1111;
`ifdef LSU_MISALIGN_TRAP_EN
        case (req_f3_i)
            F3_BYTE, F3_BYTE_U:         trap_d = 1'b0;
            F3_HALFWORD, F3_HALFWORD_U: trap_d = req_addr_i[0];
            default:                    trap_d = |req_addr_i[1:0];
        endcase
`endif
    end

    always_comb begin
        byte_v    = mem_rdata_i[{lane_q, 3'b000} +: 8];
        half_v    = mem_rdata_i[{lane_q[1], 4'b0000} +: 16];
        load_data = mem_rdata_i;
        case (f3_q)
            F3_BYTE:       load_data = {{24{byte_v[7]}}, byte_v};
            F3_BYTE_U:     load_data = {24'b0, byte_v};
            F3_HALFWORD:   load_data = {{16{half_v[15]}}, half_v};
            F3_HALFWORD_U: load_data = {16'b0, half_v};
            default:       load_data = mem_rdata_i;
        endcase
    end

    always_comb begin
        state_d   = state;
        stall_o   = 1'b0;
        mem_req_o = 1'b0;
        case (state)
            IDLE: begin
                stall_o = req_valid_i;
                if (req_valid_i) state_d = trap_d ? DONE : REQ;
            end
            REQ: begin
                stall_o   = 1'b1;
                mem_req_o = 1'b1;
                if (mem_ack_i || cnt == CNT_LAST) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            f3_q        <= 3'b0;
            lane_q      <= 2'b0;
            rdata_q     <= 32'b0;
            err_q       <= 1'b0;
            mis_q       <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'b0;
            mem_wdata_o <= 32'b0;
            mem_be_o    <= 4'b0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: if (req_valid_i) begin
                    cnt         <= '0;
                    f3_q        <= req_f3_i;
                    lane_q      <= req_addr_i[1:0];
                    rdata_q     <= 32'b0;
                    err_q       <= 1'b0;
                    mis_q       <= trap_d;
                    mem_we_o    <= req_is_store_i;
                    mem_addr_o  <= {req_addr_i[31:2], 2'b00};
                    mem_wdata_o <= wdata_d;
                    mem_be_o    <= be_d;
                end
                REQ: begin
                    cnt <= cnt + CNT_W'(1);
                    if (mem_ack_i) begin
                        if (!mem_we_o) rdata_q <= load_data;
                    end else if (cnt == CNT_LAST) begin
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Result is only visible during DONE so the pulses last exactly one cycle
    always_comb begin
        wb.valid = (state == DONE) && !mem_we_o && !err_q && !mis_q;
        wb.data  = wb.valid ? rdata_q : 32'b0;
    end

    assign wb_o  = wb;
    assign err_o = (state == DONE) && err_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_o = (state == DONE) && mis_q;
`else
    assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_holy_lsu.sv
// tb/tb_holy_lsu.sv - table-driven bench for holy_lsu (TIMEOUT_CYCLES=4)
module tb_holy_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_is_store_i;
    logic [2:0]  req_f3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        stall_o;
    logic [32:0] wb_o;
    logic        err_o;
    logic        misalign_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    int checks = 0;
    int errors = 0;

    holy_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_is_store_i(req_is_store_i),
        .req_f3_i(req_f3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .stall_o(stall_o), .wb_o(wb_o), .err_o(err_o), .misalign_o(misalign_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          dly;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        int          reqs;
        logic [31:0] wbd;
        logic        wbv;
        logic        err;
        logic        mis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata, input int dly,
                                input logic [3:0] be, input logic [31:0] maddr, input logic [31:0] mwdata,
                                input int reqs, input logic [31:0] wbd, input logic wbv,
                                input logic err, input logic mis);
        vec_t v;
        v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.dly = dly;
        v.be = be; v.maddr = maddr; v.mwdata = mwdata; v.reqs = reqs;
        v.wbd = wbd; v.wbv = wbv; v.err = err; v.mis = mis;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  stalls;
        int  reqs;
        bit  done;
        stalls = 0;
        reqs   = 0;
        done   = 0;
        @(negedge clk);
        req_valid_i    = 1'b1;
        req_is_store_i = v.st;
        req_f3_i       = v.f3;
        req_addr_i     = v.addr;
        req_wdata_i    = v.wdata;
        mem_rdata_i    = v.rdata;
        mem_ack_i      = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (stall_o) stalls++;
            if (mem_req_o) begin
                reqs++;
                if (reqs == 1) begin
                    chk($sformatf("v%0d mem_addr", idx), mem_addr_o, v.maddr);
                    chk($sformatf("v%0d mem_be", idx), mem_be_o, v.be);
                    chk($sformatf("v%0d mem_we", idx), mem_we_o, v.st);
                    if (v.st) chk($sformatf("v%0d mem_wdata", idx), mem_wdata_o, v.mwdata);
                end
                mem_ack_i = (reqs > v.dly);
            end else begin
                mem_ack_i = 1'b0;
            end
            if (!stall_o) begin
                done = 1;
                chk($sformatf("v%0d wb_valid", idx), wb_o[0], v.wbv);
                if (!v.st) chk($sformatf("v%0d wb_data", idx), wb_o[32:1], v.wbd);
                chk($sformatf("v%0d err", idx), err_o, v.err);
                chk($sformatf("v%0d misalign", idx), misalign_o, v.mis);
                chk($sformatf("v%0d req_cycles", idx), reqs, v.reqs);
                chk($sformatf("v%0d stall_cycles", idx), stalls, 1 + v.reqs);
            end else begin
                @(negedge clk);
            end
        end
        if (!done) chk($sformatf("v%0d done_reached", idx), 0, 1);
        @(negedge clk);
        req_valid_i = 1'b0;
        mem_ack_i   = 1'b0;
        #1;
        chk($sformatf("v%0d post_wb", idx), wb_o, 33'b0);
        chk($sformatf("v%0d post_pulses", idx), {err_o, misalign_o, mem_req_o, stall_o}, 4'b0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid_i = 1'b0; req_is_store_i = 1'b0; req_f3_i = 3'b0;
        req_addr_i = 32'b0; req_wdata_i = 32'b0; mem_ack_i = 1'b0; mem_rdata_i = 32'b0;

        //         st   f3      addr          wdata         rdata        dly be       maddr         mwdata       reqs wbd           v  e  m
        vecs.push_back(mk(0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 4'b1111, 32'h0000_1000, 32'h0,        1, 32'hFFFF_FF80, 1, 0, 0));
        vecs.push_back(mk(0, 3'b101, 32'h0000_2002, 32'h0,        32'hBEEF_0000, 3, 4'b1111, 32'h0000_2000, 32'h0,        4, 32'h0000_BEEF, 1, 0, 0));
        vecs.push_back(mk(1, 3'b000, 32'h0000_0001, 32'h1234_56AB, 32'h0,        1, 4'b0010, 32'h0000_0000, 32'hABAB_ABAB, 2, 32'h0,        0, 0, 0));
        vecs.push_back(mk(1, 3'b010, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0,       99, 4'b1111, 32'h0000_0040, 32'hDEAD_BEEF, 4, 32'h0,        0, 1, 0));
        vecs.push_back(mk(0, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 0, 4'b1111, 32'h0000_0100, 32'h0,        1, 32'hFFFF_8001, 1, 0, 0));
        vecs.push_back(mk(0, 3'b100, 32'h0000_0201, 32'h0,        32'h1234_C5AA, 2, 4'b1111, 32'h0000_0200, 32'h0,        3, 32'h0000_00C5, 1, 0, 0));
        vecs.push_back(mk(0, 3'b010, 32'h0000_0300, 32'h0,        32'hCAFE_F00D, 0, 4'b1111, 32'h0000_0300, 32'h0,        1, 32'hCAFE_F00D, 1, 0, 0));
        vecs.push_back(mk(1, 3'b001, 32'h0000_0012, 32'hAAAA_5678, 32'h0,        0, 4'b1100, 32'h0000_0010, 32'h5678_5678, 1, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 3'b111, 32'h0000_0020, 32'h0,        32'h1122_3344, 0, 4'b1111, 32'h0000_0020, 32'h0,        1, 32'h1122_3344, 1, 0, 0));
        vecs.push_back(mk(1, 3'b011, 32'h0000_0024, 32'h0102_0304, 32'h0,        0, 4'b1111, 32'h0000_0024, 32'h0102_0304, 1, 32'h0,        0, 0, 0));
        vecs.push_back(mk(0, 3'b000, 32'h0000_0000, 32'h0,        32'h0000_007F, 0, 4'b1111, 32'h0000_0000, 32'h0,        1, 32'h0000_007F, 1, 0, 0));
        vecs.push_back(mk(0, 3'b001, 32'h0000_0004, 32'h0,        32'h0000_8000, 1, 4'b1111, 32'h0000_0004, 32'h0,        2, 32'hFFFF_8000, 1, 0, 0));
        vecs.push_back(mk(0, 3'b000, 32'h0000_0033, 32'h0,        32'h5555_5555,99, 4'b1111, 32'h0000_0030, 32'h0,        4, 32'h0,        0, 1, 0));
`ifdef LSU_MISALIGN_TRAP_EN
        vecs.push_back(mk(0, 3'b010, 32'h0000_0002, 32'h0,        32'h7654_3210, 0, 4'b1111, 32'h0000_0000, 32'h0,        0, 32'h0,        0, 0, 1));
        vecs.push_back(mk(0, 3'b001, 32'h0000_0007, 32'h0,        32'hA5A5_1234, 0, 4'b1111, 32'h0000_0004, 32'h0,        0, 32'h0,        0, 0, 1));
`else
        vecs.push_back(mk(0, 3'b010, 32'h0000_0002, 32'h0,        32'h7654_3210, 0, 4'b1111, 32'h0000_0000, 32'h0,        1, 32'h7654_3210, 1, 0, 0));
        vecs.push_back(mk(0, 3'b001, 32'h0000_0007, 32'h0,        32'hA5A5_1234, 0, 4'b1111, 32'h0000_0004, 32'h0,        1, 32'hFFFF_A5A5, 1, 0, 0));
`endif

        #1;
        chk("reset_mem", {mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}, 70'b0);
        chk("reset_wb", wb_o, 33'b0);
        chk("reset_flags", {err_o, misalign_o, stall_o}, 3'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

        // Reset during the second REQ cycle of a load
        @(negedge clk);
        req_valid_i = 1'b1; req_is_store_i = 1'b0; req_f3_i = 3'b010;
        req_addr_i = 32'h0000_0500; mem_ack_i = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2;
        chk("rst_pre_req", mem_req_o, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_req_drop", mem_req_o, 1'b0);
        chk("rst_wb_zero", wb_o, 33'b0);
        @(negedge clk);
        req_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_idle", {mem_req_o, stall_o}, 2'b0);
        run_vec(100, vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
